// File: rtl/uart_pkg.sv
// Shared UART block types and defaults.
// Holds the arbiter state encoding and index-width helper.
package uart_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_START = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

  localparam int N_REQ_DEF   = 4;
  localparam int DBITS_DEF   = 8;
  localparam int TIMEOUT_DEF = 4096;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int IDX_W_DEF = idx_w(N_REQ_DEF);

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin pick: first set valid
// bit scanning upward from ptr+1, wrapping.
module uart_rr_picker
  import uart_pkg::*;
#(
  parameter int N  = N_REQ_DEF,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0] cand;
  logic          found;

  // walk the ring once starting after ptr; keep the first hit
  always_comb begin
    found = 1'b0;
    cand  = '0;
    idx_o = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr_i) + k) % N);
      if (!found && valid_i[cand]) begin
        found = 1'b1;
        idx_o = cand;
      end
    end
  end

  assign any_o = |valid_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter.
// Optional transmitter watchdog: UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ       = N_REQ_DEF,
  parameter int DBITS       = DBITS_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*DBITS-1:0]   req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     tx_start,
  output logic [DBITS-1:0]         tx_data,
  input  logic                     tx_done_tick,
  output logic                     busy,
  output logic [idx_w(N_REQ)-1:0]  grant_id,
  output logic                     timeout_err
);

  localparam int IW = idx_w(N_REQ);

  if (N_REQ < 2 || TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("uart_tx_arbiter: N_REQ and TIMEOUT_CYC must be >= 2");
  end

  arb_state_e       state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    gnt_q, gnt_d;
  logic [DBITS-1:0] data_q, data_d;
  logic [IW-1:0]    win;
  logic             any_v;
  logic             tout_w;

  uart_rr_picker #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .idx_o   (win),
    .any_o   (any_v)
  );

`ifdef UART_ARB_TIMEOUT_EN
  localparam int            CW       = idx_w(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q;

  // wait counter: cleared entering WAIT, saturates at last
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ARB_START) begin
      cnt_d = '0;
    end else if (state_q == ARB_WAIT && cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign tout_w = (state_q == ARB_WAIT) && !tx_done_tick
                  && (cnt_d == CNT_LAST);

  // watchdog registers; error pulse follows the bail-out edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= tout_w;
    end
  end

  assign timeout_err = err_q;
`else
  assign tout_w      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // next state: capture winner in IDLE, release on done/timeout
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    data_d  = data_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (any_v) begin
          gnt_d   = win;
          data_d  = req_data[win*DBITS +: DBITS];
          state_d = ARB_START;
        end
      end
      ARB_START: state_d = ARB_WAIT;
      ARB_WAIT: begin
        if (tx_done_tick || tout_w) begin
          ptr_d   = gnt_q;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // state, pointer, grant and byte registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      ptr_q   <= IW'(N_REQ - 1);
      gnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
    end
  end

  // one-hot acceptance decoded from START
  always_comb begin
    req_ready = '0;
    if (state_q == ARB_START) req_ready[gnt_q] = 1'b1;
  end

  assign tx_start = (state_q == ARB_START);
  assign busy     = (state_q != ARB_IDLE);
  assign tx_data  = data_q;
  assign grant_id = gnt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter.
// Transaction model plus directed literal checks.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DB = 8;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DB-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            tx_start;
  logic [DB-1:0]   tx_data;
  logic            tx_done_tick;
  logic            busy;
  logic [1:0]      grant_id;
  logic            timeout_err;

  uart_tx_arbiter #(
    .N_REQ       (N),
    .DBITS       (DB),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_done_tick (tx_done_tick),
    .busy         (busy),
    .grant_id     (grant_id),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 1; k <= N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  function automatic logic [DB-1:0] byte_of(input logic [N*DB-1:0] d,
                                            input int i);
    return d[i*DB +: DB];
  endfunction

  // transaction-level model: phase 0 idle, 1 granted, 2 frame out
  int            m_ph, m_ptr, m_gid, m_wait;
  logic [DB-1:0] m_data;
  logic          m_err;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ph   <= 0;
      m_ptr  <= N - 1;
      m_gid  <= 0;
      m_data <= '0;
      m_wait <= 0;
      m_err  <= 1'b0;
    end else begin
      m_err <= 1'b0;
      if (m_ph == 0) begin
        if (req_valid != 0) begin
          m_gid  <= rr_pick(req_valid, m_ptr);
          m_data <= byte_of(req_data, rr_pick(req_valid, m_ptr));
          m_ph   <= 1;
        end
      end else if (m_ph == 1) begin
        m_ph   <= 2;
        m_wait <= 0;
      end else begin
        m_wait <= m_wait + 1;
        if (tx_done_tick) begin
          m_ptr <= m_gid;
          m_ph  <= 0;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (m_wait + 1 == TO - 1) begin
          m_ptr <= m_gid;
          m_ph  <= 0;
          m_err <= 1'b1;
        end
`endif
      end
    end
  end

  int g_log[$];
  int rdy1    = 0;
  int rdy_any = 0;

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (rst) begin
      chk("busy", busy, m_ph != 0);
      chk("tx_start", tx_start, m_ph == 1);
      chk("req_ready", req_ready, (m_ph == 1) ? (1 << m_gid) : 0);
      chk("tx_data", tx_data, m_data);
      chk("grant_id", grant_id, m_gid);
      chk("timeout_err", timeout_err, m_err);
      if (tx_start) g_log.push_back(int'(grant_id));
      if (req_ready[1]) rdy1++;
      if (req_ready != 0) rdy_any++;
    end
  end

  task automatic wait_start(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!tx_start && k < 40);
    chk("wait_start", tx_start, 1);
  endtask

  task automatic pulse_done(input int n);
    repeat (n) @(negedge clk);
    tx_done_tick = 1'b1;
    @(negedge clk);
    tx_done_tick = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, base, rb;
    int exp_b[5];
    exp_b = '{0, 1, 2, 3, 0};
    rst          = 1'b0;
    req_valid    = '0;
    req_data     = '0;
    tx_done_tick = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_err", timeout_err, 0);
    rst = 1'b1;

    // single requester 2 with 0xA5
    req_data[2*DB +: DB] = 8'hA5;
    req_valid = 4'b0100;
    wait_start(k);
    chk("a_latency", k, 1);
    chk("a_ready", req_ready, 4'b0100);
    chk("a_data", tx_data, 8'hA5);
    chk("a_gid", grant_id, 2);
    @(negedge clk);
    req_valid = '0;
    pulse_done(19);

    // reset in IDLE so the pointer starts over
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // all four held: order 0,1,2,3,0
    base = g_log.size();
    rb = rdy_any;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    req_valid = 4'hF;
    for (int f = 0; f < 5; f++) begin
      wait_start(k);
      chk("b_data", tx_data, 8'h10 + f % 4);
      @(negedge clk);
      if (f == 4) req_valid = '0;
      pulse_done(19);
    end
    for (int i = 0; i < 5; i++)
      chk("b_order", g_log[base + i], exp_b[i]);
    chk("b_ready_pulses", rdy_any - rb, 5);

    // requester 1 held across frames: one accept per frame
    rb = rdy1;
    req_data[1*DB +: DB] = 8'h5C;
    req_valid = 4'b0010;
    wait_start(k);
    pulse_done(20);
    wait_start(k);
    chk("c_gid", grant_id, 1);
    @(negedge clk);
    req_valid = '0;
    pulse_done(19);
    repeat (3) @(negedge clk);
    chk("c_one_per_frame", rdy1 - rb, 2);

    // done in IDLE is ignored; pointer stays at 1
    tx_done_tick = 1'b1;
    @(negedge clk);
    tx_done_tick = 1'b0;
    chk("d_idle_busy", busy, 0);
    repeat (2) @(negedge clk);
    req_data[0*DB +: DB] = 8'h0D;
    req_data[2*DB +: DB] = 8'h2D;
    req_valid = 4'b0101;
    wait_start(k);
    chk("d_gid", grant_id, 2);
    chk("d_data", tx_data, 8'h2D);
    @(negedge clk);
    req_valid = '0;
    pulse_done(19);

    // reset during WAIT, then pointer must be back at 3
    req_data[0*DB +: DB] = 8'hE0;
    req_data[3*DB +: DB] = 8'hE3;
    req_valid = 4'b0001;
    wait_start(k);
    @(negedge clk);
    req_valid = '0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("e_async_busy", busy, 0);
    chk("e_async_start", tx_start, 0);
    chk("e_async_ready", req_ready, 0);
    chk("e_async_data", tx_data, 0);
    chk("e_async_gid", grant_id, 0);
    @(negedge clk);
    rst = 1'b1;
    req_valid = 4'b1001;
    wait_start(k);
    chk("e_gid0", grant_id, 0);
    @(negedge clk);
    req_valid = 4'b1000;
    pulse_done(19);
    wait_start(k);
    chk("e_gid3", grant_id, 3);
    chk("e_data3", tx_data, 8'hE3);
    @(negedge clk);
    req_valid = '0;
    pulse_done(19);

`ifdef UART_ARB_TIMEOUT_EN
    // withhold done: error 15 cycles after WAIT entry
    req_valid = 4'b0110;
    wait_start(k);
    chk("t_gid", grant_id, 1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!timeout_err && k < 40);
    chk("t_latency", k, 16);
    chk("t_idle", busy, 0);
    wait_start(k);
    chk("t_next_gid", grant_id, 2);
    @(negedge clk);
    req_valid = '0;
    pulse_done(19);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
